// File: rtl/bus_mem_responder_if.sv
// Valid/ready memory bus between a program initiator and a memory target.
// Request fields flow master to slave; completion flows back.
interface bus_mem_responder_if #(
    parameter int AW = 32
);
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic          valid;
    logic          write;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ready;
    logic          err;
    logic          busy;

    modport master (
        output addr, size, valid, write, wdata,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  addr, size, valid, write, wdata,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/bus_mem_responder.sv
// Word-organised RAM target for the valid/ready memory bus.
// One request at a time, programmable wait states, one-cycle ready.
module bus_mem_responder #(
    parameter int            AW          = 32,
    parameter int            DEPTH_LOG2  = 8,
    parameter logic [AW-1:0] BASE        = '0,
    parameter int            WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_mem_responder_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2:0]      size_q, size_d;
    logic            write_q, write_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0]     mem [DEPTH];

    logic                  idle;
    logic [AW-1:0]         r_addr;
    logic [2:0]            r_size;
    logic                  r_write;
    logic [31:0]           r_wdata;
    logic [AW-1:0]         diff;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            off;
    logic                  oor;
    logic                  fault;
    logic                  enter_resp;
    logic                  mem_we;
    logic [3:0]            be;
    logic [31:0]           wlane;

    // Request view: the live bus while idle (zero-wait path), the latched copy later.
    always_comb begin
        idle    = (state_q == S_IDLE);
        r_addr  = idle ? bus.addr  : addr_q;
        r_size  = idle ? bus.size  : size_q;
        r_write = idle ? bus.write : write_q;
        r_wdata = idle ? bus.wdata : wdata_q;
        diff    = r_addr - BASE;
        idx     = diff[DEPTH_LOG2+1:2];
        off     = diff[1:0];
        oor     = (r_addr < BASE) || (diff[AW-1:DEPTH_LOG2+2] != '0);
        fault   = oor || (r_size > 3'd2)
                || (r_size == 3'd1 && off == 2'd3)
                || (r_size == 3'd2 && off != 2'd0);
    end

    // Byte-lane enables and lane-shifted store data.
    always_comb begin
        be    = 4'b0000;
        wlane = r_wdata << {off, 3'b000};
        unique case (r_size)
            3'd0:    be = 4'b0001 << off;
            3'd1:    be = 4'b0011 << off;
            3'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Next-state, request latch and response data; rdata/err are zero outside RESP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        size_d     = size_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        rdata_d    = 32'h0;
        err_d      = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.valid) begin
                    addr_d  = bus.addr;
                    size_d  = bus.size;
                    write_d = bus.write;
                    wdata_d = bus.wdata;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (enter_resp) begin
            err_d   = fault;
            rdata_d = (fault || r_write) ? 32'h0 : mem[idx];
        end
        mem_we = enter_resp && r_write && !fault;
    end

    // Control and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array; contents survive reset, store commits entering RESP.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && be[i]) begin
                mem[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    assign bus.ready = (state_q == S_RESP);
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder.
// Three targets with 1, 0 and 3 wait states share one request driver.
module tb_bus_mem_responder;
    localparam int WSV [3] = '{1, 0, 3};

    logic        clk;
    logic        rst;
    logic [31:0] t_addr;
    logic [2:0]  t_size;
    logic        t_write;
    logic [31:0] t_wdata;
    logic        vld   [3];
    logic        rdy   [3];
    logic        err   [3];
    logic        busy  [3];
    logic [31:0] rdata [3];
    logic        prv   [3];
    int          rcnt  [3];
    logic [32:0] sbq   [3][$];
    int          n_tests;
    int          n_fail;

    bus_mem_responder_if #(.AW(32)) if_a ();
    bus_mem_responder_if #(.AW(32)) if_b ();
    bus_mem_responder_if #(.AW(32)) if_c ();

    bus_mem_responder #(.WAIT_STATES(1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );
    bus_mem_responder #(.WAIT_STATES(0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );
    bus_mem_responder #(.WAIT_STATES(3)) u_dut_c (
        .clk (clk),
        .rst (rst),
        .bus (if_c)
    );

    assign if_a.addr  = t_addr;
    assign if_a.size  = t_size;
    assign if_a.write = t_write;
    assign if_a.wdata = t_wdata;
    assign if_a.valid = vld[0];
    assign if_b.addr  = t_addr;
    assign if_b.size  = t_size;
    assign if_b.write = t_write;
    assign if_b.wdata = t_wdata;
    assign if_b.valid = vld[1];
    assign if_c.addr  = t_addr;
    assign if_c.size  = t_size;
    assign if_c.write = t_write;
    assign if_c.wdata = t_wdata;
    assign if_c.valid = vld[2];

    assign rdy[0]   = if_a.ready;
    assign rdy[1]   = if_b.ready;
    assign rdy[2]   = if_c.ready;
    assign err[0]   = if_a.err;
    assign err[1]   = if_b.err;
    assign err[2]   = if_c.err;
    assign busy[0]  = if_a.busy;
    assign busy[1]  = if_b.busy;
    assign busy[2]  = if_c.busy;
    assign rdata[0] = if_a.rdata;
    assign rdata[1] = if_b.rdata;
    assign rdata[2] = if_c.rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Response monitor: every ready pulse pops one expected {err, rdata}.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rdy[d] === 1'b1) begin
                rcnt[d]++;
                chk("rdy_width", 32'(prv[d]), 32'd0);
                chk("busy_resp", 32'(busy[d]), 32'd1);
                if (sbq[d].size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    logic [32:0] e;
                    e = sbq[d].pop_front();
                    chk("rdata", rdata[d], e[31:0]);
                    chk("err", 32'(err[d]), 32'(e[32]));
                end
            end
            prv[d] = rdy[d];
        end
    end

    // One request on target d, expected result pushed as it is driven.
    task automatic acc(input int d, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
        int  n;
        bit  ok;
        sbq[d].push_back({exp_err, exp_rd});
        t_addr  = a;
        t_size  = sz;
        t_write = wr;
        t_wdata = wd;
        vld[d]  = 1'b1;
        @(posedge clk);
        #1 vld[d] = 1'b0;
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy[d] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) chk("timeout", 32'd0, 32'd1);
        else     chk("latency", 32'(n), 32'(WSV[d]));
        @(posedge clk);
        #1;
        chk("idle_rdata", rdata[d], 32'h0);
        chk("idle_err", 32'(err[d]), 32'd0);
    endtask

    task automatic fib(input int d);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        a = 32'd0;
        b = 32'd1;
        acc(d, 1'b1, 3'd2, 32'h100, a, 32'h0, 1'b0);
        acc(d, 1'b1, 3'd2, 32'h104, b, 32'h0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            acc(d, 1'b0, 3'd2, 32'h100, 32'h0, a, 1'b0);
            acc(d, 1'b0, 3'd2, 32'h104, 32'h0, b, 1'b0);
            s = a + b;
            a = b;
            b = s;
            acc(d, 1'b1, 3'd2, 32'h100, a, 32'h0, 1'b0);
            acc(d, 1'b1, 3'd2, 32'h104, b, 32'h0, 1'b0);
        end
        acc(d, 1'b1, 3'd2, 32'h108, b, 32'h0, 1'b0);
        acc(d, 1'b1, 3'd2, 32'h10C, 32'hFFFF_FFFF, 32'h0, 1'b0);
        acc(d, 1'b0, 3'd2, 32'h100, 32'h0, 32'd5, 1'b0);
        acc(d, 1'b0, 3'd2, 32'h104, 32'h0, 32'd8, 1'b0);
        acc(d, 1'b0, 3'd2, 32'h108, 32'h0, 32'd8, 1'b0);
        acc(d, 1'b0, 3'd2, 32'h10C, 32'h0, 32'hFFFF_FFFF, 1'b0);
        chk("fib_idle", 32'(busy[d]), 32'd0);
    endtask

    initial begin
        int c0;
        n_tests = 0;
        n_fail  = 0;
        for (int d = 0; d < 3; d++) begin
            vld[d]  = 1'b0;
            prv[d]  = 1'b0;
            rcnt[d] = 0;
        end
        t_addr  = '0;
        t_size  = '0;
        t_write = 1'b0;
        t_wdata = '0;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(rdy[0]), 32'd0);
        chk("rst_err", 32'(err[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_rdata", rdata[0], 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a store.
        acc(0, 1'b1, 3'd2, 32'h10, 32'h1111_1111, 32'h0, 1'b0);
        t_addr  = 32'h10;
        t_size  = 3'd2;
        t_write = 1'b1;
        t_wdata = 32'h2222_2222;
        vld[0]  = 1'b1;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        chk("busy_wait", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_ready", 32'(rdy[0]), 32'd0);
        chk("arst_busy", 32'(busy[0]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        acc(0, 1'b0, 3'd2, 32'h10, 32'h0, 32'h1111_1111, 1'b0);

        // Word store and load.
        acc(0, 1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0);
        acc(0, 1'b0, 3'd2, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Level-held valid: one access per three cycles, none inside RESP.
        for (int i = 0; i < 3; i++) sbq[0].push_back({1'b0, 32'hDEAD_BEEF});
        t_addr  = 32'h8;
        t_size  = 3'd2;
        t_write = 1'b0;
        c0      = rcnt[0];
        vld[0]  = 1'b1;
        repeat (9) @(posedge clk);
        #1 vld[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_cnt", 32'(rcnt[0] - c0), 32'd3);

        // Re-pulsing during WAIT and RESP is ignored.
        sbq[0].push_back({1'b0, 32'hDEAD_BEEF});
        c0     = rcnt[0];
        vld[0] = 1'b1;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        #2 vld[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 vld[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pulse_cnt", 32'(rcnt[0] - c0), 32'd1);

        // Byte and half lane placement; loads come back unshifted.
        acc(0, 1'b1, 3'd2, 32'h4, 32'h0, 32'h0, 1'b0);
        acc(0, 1'b1, 3'd0, 32'h5, 32'hFFFF_FFAA, 32'h0, 1'b0);
        acc(0, 1'b1, 3'd1, 32'h6, 32'hFFFF_1234, 32'h0, 1'b0);
        acc(0, 1'b0, 3'd2, 32'h4, 32'h0, 32'h1234_AA00, 1'b0);
        acc(0, 1'b0, 3'd0, 32'h7, 32'h0, 32'h1234_AA00, 1'b0);
        acc(0, 1'b1, 3'd1, 32'h9, 32'h0000_5566, 32'h0, 1'b0);
        acc(0, 1'b0, 3'd1, 32'hA, 32'h0, 32'hDE55_66EF, 1'b0);

        // Faulty requests leave memory untouched.
        acc(0, 1'b1, 3'd2, 32'h0, 32'h5566_7788, 32'h0, 1'b0);
        acc(0, 1'b1, 3'd2, 32'h2, 32'hAAAA_AAAA, 32'h0, 1'b1);
        acc(0, 1'b1, 3'd1, 32'h3, 32'hBBBB_BBBB, 32'h0, 1'b1);
        acc(0, 1'b1, 3'd3, 32'h0, 32'hCCCC_CCCC, 32'h0, 1'b1);
        acc(0, 1'b1, 3'd7, 32'h4, 32'hCCCC_CCCC, 32'h0, 1'b1);
        acc(0, 1'b1, 3'd2, 32'h400, 32'h9999_9999, 32'h0, 1'b1);
        acc(0, 1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 1'b1);
        acc(0, 1'b0, 3'd2, 32'h1_0000, 32'h0, 32'h0, 1'b1);
        acc(0, 1'b0, 3'd2, 32'h0, 32'h0, 32'h5566_7788, 1'b0);
        acc(0, 1'b0, 3'd2, 32'h4, 32'h0, 32'h1234_AA00, 1'b0);

        // Fibonacci-style program on every wait-state setting.
        for (int d = 0; d < 3; d++) fib(d);

        for (int d = 0; d < 3; d++) chk("sb_left", 32'(sbq[d].size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
